axi_r_resp_router: RTL

//  Return-path counterpart of the AXI address decoder: collects read-data (R) beats from slaves S0..S4
//  and routes each burst to the master that issued it, using the master tag in RID[7:4].
//  One independent lock FSM per master; round-robin among slaves targeting the same master.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/r_rr_arbiter.sv | 26 ++
 rtl/axi_r_resp_router.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared constants, beat record and FSM encoding for the AXI R-channel return router.
package axi_pkg;

  localparam int NUM_S     = 5;
  localparam int NUM_M     = 2;
  localparam int ID_M_BITS = 4;
  localparam int ID_S_BITS = 2 * ID_M_BITS;
  localparam int DATA_BITS = 32;
  localparam int SIDX_W    = $clog2(NUM_S);

  typedef struct packed {
    logic [ID_M_BITS-1:0] id;
    logic [DATA_BITS-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_beat_t;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} fsm_e;

  function automatic logic [SIDX_W-1:0] oh2idx(input logic [NUM_S-1:0] oh);
    logic [SIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (oh[i]) idx = SIDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SIDX_W-1:0] inc_wrap(input logic [SIDX_W-1:0] i);
    return (i == SIDX_W'(NUM_S - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/r_rr_arbiter.sv
// NUM_S-way round-robin arbiter: first requester at or after ptr_i wins, one-hot grant.
module r_rr_arbiter
  import axi_pkg::*;
(
  input  logic [NUM_S-1:0]  req_i,
  input  logic [SIDX_W-1:0] ptr_i,
  output logic [NUM_S-1:0]  gnt_o
);

  int idx;

  // Scan from the farthest candidate back to ptr_i so the nearest one overrides.
  always_comb begin
    gnt_o = '0;
    idx   = 0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_S) idx = idx - NUM_S;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_r_resp_router.sv
// Routes slave R bursts to the master named by RID[7:4], with one burst lock per master.
// Optional: define AXI_R_SKID_EN for a registered 2-entry skid buffer on each master R path.
//
// state | meaning
// IDLE  | no burst owned; arbiter grant applies combinationally this cycle
// LOCK  | burst in progress from slave gnt_q; released by the RLAST handshake
module axi_r_resp_router
  import axi_pkg::*;
(
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [NUM_S-1:0][ID_S_BITS-1:0]     RID_S,
  input  logic [NUM_S-1:0][DATA_BITS-1:0]     RDATA_S,
  input  logic [NUM_S-1:0][1:0]               RRESP_S,
  input  logic [NUM_S-1:0]                    RLAST_S,
  input  logic [NUM_S-1:0]                    RVALID_S,
  output logic [NUM_S-1:0]                    RREADY_S,
  output logic [NUM_M-1:0][ID_M_BITS-1:0]     RID_M,
  output logic [NUM_M-1:0][DATA_BITS-1:0]     RDATA_M,
  output logic [NUM_M-1:0][1:0]               RRESP_M,
  output logic [NUM_M-1:0]                    RLAST_M,
  output logic [NUM_M-1:0]                    RVALID_M,
  input  logic [NUM_M-1:0]                    RREADY_M
);

  fsm_e              state_q [NUM_M];
  fsm_e              state_d [NUM_M];
  logic [SIDX_W-1:0] gnt_q   [NUM_M];
  logic [SIDX_W-1:0] gnt_d   [NUM_M];
  logic [SIDX_W-1:0] ptr_q   [NUM_M];
  logic [SIDX_W-1:0] ptr_d   [NUM_M];
  logic [SIDX_W-1:0] sel     [NUM_M];

  logic [NUM_M-1:0][NUM_S-1:0] req;
  logic [NUM_M-1:0][NUM_S-1:0] arb_gnt;
  logic [NUM_M-1:0]            active, fwd_valid, fwd_ready, accept;
  r_beat_t                     beat_s   [NUM_S];
  r_beat_t                     fwd_beat [NUM_M];
  r_beat_t                     out_beat [NUM_M];

  always_comb begin
    req = '0;
    for (int s = 0; s < NUM_S; s++) begin
      beat_s[s].id   = RID_S[s][ID_M_BITS-1:0];
      beat_s[s].data = RDATA_S[s];
      beat_s[s].resp = RRESP_S[s];
      beat_s[s].last = RLAST_S[s];
      for (int m = 0; m < NUM_M; m++) begin
        req[m][s] = RVALID_S[s] && (RID_S[s][ID_S_BITS-1:ID_M_BITS] == ID_M_BITS'(m));
      end
    end
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_arb
    r_rr_arbiter u_arb (
      .req_i (req[m]),
      .ptr_i (ptr_q[m]),
      .gnt_o (arb_gnt[m])
    );
  end

  // Reset gates every ready/valid so a partial burst is dropped the moment ARESETn falls.
  always_comb begin
    RREADY_S = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (ARESETn && RVALID_S[s] &&
          (RID_S[s][ID_S_BITS-1:ID_M_BITS] >= ID_M_BITS'(NUM_M)))
        RREADY_S[s] = 1'b1;
    end
    for (int m = 0; m < NUM_M; m++) begin
      sel[m]       = (state_q[m] == LOCK) ? gnt_q[m] : oh2idx(arb_gnt[m]);
      active[m]    = ARESETn && ((state_q[m] == LOCK) || (|req[m]));
      fwd_valid[m] = active[m] && RVALID_S[sel[m]];
      fwd_beat[m]  = active[m] ? beat_s[sel[m]] : '0;
      accept[m]    = fwd_valid[m] && fwd_ready[m];
      if (active[m] && fwd_ready[m]) RREADY_S[sel[m]] = 1'b1;
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      state_d[m] = state_q[m];
      gnt_d[m]   = gnt_q[m];
      ptr_d[m]   = ptr_q[m];
      if (active[m]) begin
        if (accept[m] && fwd_beat[m].last) begin
          state_d[m] = IDLE;
          ptr_d[m]   = inc_wrap(sel[m]);
        end else begin
          state_d[m] = LOCK;
          gnt_d[m]   = sel[m];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= IDLE;
        gnt_q[m]   <= '0;
        ptr_q[m]   <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= state_d[m];
        gnt_q[m]   <= gnt_d[m];
        ptr_q[m]   <= ptr_d[m];
      end
    end
  end

`ifdef AXI_R_SKID_EN
  r_beat_t    sk_q  [NUM_M][2];
  r_beat_t    sk_d  [NUM_M][2];
  logic [1:0] cnt_q [NUM_M];
  logic [1:0] cnt_d [NUM_M];

  for (genvar m = 0; m < NUM_M; m++) begin : g_rdy
    assign fwd_ready[m] = (cnt_q[m] != 2'd2);
  end

  // Pop shifts entry 1 down first, so a same-cycle push lands at the post-pop count.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      sk_d[m][0] = sk_q[m][0];
      sk_d[m][1] = sk_q[m][1];
      cnt_d[m]   = cnt_q[m];
      RVALID_M[m] = (cnt_q[m] != 2'd0);
      out_beat[m] = RVALID_M[m] ? sk_q[m][0] : '0;
      if (RVALID_M[m] && RREADY_M[m]) begin
        sk_d[m][0] = sk_q[m][1];
        cnt_d[m]   = cnt_q[m] - 2'd1;
      end
      if (accept[m]) begin
        sk_d[m][cnt_d[m][0]] = fwd_beat[m];
        cnt_d[m]             = cnt_d[m] + 2'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        sk_q[m][0] <= '0;
        sk_q[m][1] <= '0;
        cnt_q[m]   <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        sk_q[m][0] <= sk_d[m][0];
        sk_q[m][1] <= sk_d[m][1];
        cnt_q[m]   <= cnt_d[m];
      end
    end
  end
`else
  assign fwd_ready = RREADY_M;

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      RVALID_M[m] = fwd_valid[m];
      out_beat[m] = fwd_beat[m];
    end
  end
`endif

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      RID_M[m]   = out_beat[m].id;
      RDATA_M[m] = out_beat[m].data;
      RRESP_M[m] = out_beat[m].resp;
      RLAST_M[m] = out_beat[m].last;
    end
  end

endmodule
